// File: rtl/cordic_fixedpoint_updatephase_ctrl.sv
// CORDIC phase-update sequencer: walks the theta ROM, picks the rotation
// direction from the residual sign and accumulates the residual phase.
module cordic_fixedpoint_updatephase_ctrl #(
  parameter int DATA_W = 21,
  parameter int ADDR_W = 4,
  parameter int N_ITER = 16
) (
  input  logic              iClk,
  input  logic              iRst,
  input  logic              iStart,
  input  logic [DATA_W-1:0] iTarget_phase,
  input  logic              iAbort,
  input  logic              iReady,
  input  logic [DATA_W-1:0] iTheta_value,
  output logic [ADDR_W-1:0] oAddr_theta,
  output logic              oIter_valid,
  output logic              oDir,
  output logic              oBusy,
  output logic              oDone,
  output logic [DATA_W-1:0] oPhase_residual
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ITER = 2'd1,
    DONE = 2'd2
  } state_t;

  localparam logic [ADDR_W-1:0] LAST = ADDR_W'(N_ITER - 1);

  state_t            state_q;
  logic [DATA_W-1:0] z_q;
  logic [DATA_W-1:0] z_d;
  logic [ADDR_W-1:0] addr_q;
  logic [DATA_W-1:0] res_q;
  logic              z_neg;

  assign z_neg = z_q[DATA_W-1];

  // Wraps modulo 2^DATA_W; no saturation on purpose.
  always_comb begin
    z_d = z_q;
    if (z_neg) z_d = z_q + iTheta_value;
    else       z_d = z_q - iTheta_value;
  end

  always_ff @(posedge iClk) begin
    if (iRst) begin
      state_q <= IDLE;
      z_q     <= '0;
      addr_q  <= '0;
      res_q   <= '0;
    end else begin
      unique case (state_q)
        IDLE: begin
          if (iStart) begin
            z_q     <= iTarget_phase;
            addr_q  <= '0;
            state_q <= ITER;
          end
        end
        ITER: begin
          if (iAbort) begin
            addr_q  <= '0;
            state_q <= IDLE;
          end else if (iReady) begin
            z_q <= z_d;
            if (addr_q == LAST) begin
              res_q   <= z_d;
              state_q <= DONE;
            end else begin
              addr_q <= addr_q + 1'b1;
            end
          end
        end
        DONE: begin
          addr_q  <= '0;
          state_q <= IDLE;
        end
        default: begin
          addr_q  <= '0;
          state_q <= IDLE;
        end
      endcase
    end
  end

  assign oAddr_theta     = addr_q;
  assign oIter_valid     = (state_q == ITER) && iReady;
  assign oDir            = ~z_neg;
  assign oBusy           = (state_q == ITER) || (state_q == DONE);
  assign oDone           = (state_q == DONE);
  assign oPhase_residual = res_q;

endmodule

// File: tb/tb_cordic_fixedpoint_updatephase_ctrl.sv
// Bench for the CORDIC phase-update sequencer against an integer
// reference model of the residual recurrence.
module tb_cordic_fixedpoint_updatephase_ctrl;

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic        abort;
  logic        ready;
  logic [20:0] target;
  logic [20:0] theta;
  logic [3:0]  addr;
  logic        iv;
  logic        dir;
  logic        busy;
  logic        done;
  logic [20:0] res;

  logic [20:0] rom [16];

  int checks = 0;
  int errors = 0;
  int q_dir[$];
  int q_addr[$];
  bit exp_dir [16];
  int stall_seen;
  int stall_bad;

  always #5 clk = ~clk;

  assign theta = rom[addr];

  cordic_fixedpoint_updatephase_ctrl #(
    .DATA_W(21), .ADDR_W(4), .N_ITER(16)
  ) dut (
    .iClk(clk),
    .iRst(rst),
    .iStart(start),
    .iTarget_phase(target),
    .iAbort(abort),
    .iReady(ready),
    .iTheta_value(theta),
    .oAddr_theta(addr),
    .oIter_valid(iv),
    .oDir(dir),
    .oBusy(busy),
    .oDone(done),
    .oPhase_residual(res)
  );

  function automatic int s21(input longint v);
    logic [20:0] t;
    t = v[20:0];
    return int'($signed(t));
  endfunction

  task automatic model_run(input int tgt, output int r);
    int z;
    z = s21(tgt);
    for (int i = 0; i < 16; i++) begin
      exp_dir[i] = (z >= 0);
      if (z >= 0) z = s21(longint'(z) - longint'(rom[i]));
      else        z = s21(longint'(z) + longint'(rom[i]));
    end
    r = z;
  endtask

  task automatic rom_const(input int v);
    for (int i = 0; i < 16; i++) rom[i] = 21'(v);
  endtask

  task automatic rom_atan();
    real a;
    for (int i = 0; i < 16; i++) begin
      a = $atan(2.0 ** (-i)) / 3.141592653589793 * 1048576.0;
      rom[i] = 21'(int'($ceil(a)));
    end
  endtask

  task automatic run_op(input int tgt, input int stall_at, input int stall_len,
                        input bit rnd, input bit spam, input int abort_at,
                        output int done_cyc, output int n_done,
                        output bit aborted);
    bit st;
    done_cyc   = -1;
    n_done     = 0;
    aborted    = 1'b0;
    stall_seen = 0;
    stall_bad  = 0;
    q_dir.delete();
    q_addr.delete();
    @(negedge clk);
    start  = 1'b1;
    target = 21'(tgt);
    ready  = 1'b1;
    abort  = 1'b0;
    @(posedge clk);
    #1 start = 1'b0;
    for (int cyc = 1; cyc <= 300; cyc++) begin
      @(negedge clk);
      ready = 1'b1;
      st    = 1'b0;
      start = spam ? 1'($urandom_range(0, 1)) : 1'b0;
      if (rnd) begin
        ready = 1'($urandom_range(0, 1));
      end else if (busy && !done && int'(addr) == stall_at
                   && stall_seen < stall_len) begin
        ready = 1'b0;
        st    = 1'b1;
        stall_seen++;
      end
      if (abort_at >= 0 && busy && !done && int'(addr) == abort_at)
        abort = 1'b1;
      #1;
      if (st && (iv !== 1'b0 || int'(addr) != stall_at)) stall_bad++;
      if (iv) begin
        q_dir.push_back(int'(dir));
        q_addr.push_back(int'(addr));
      end
      if (done) begin
        n_done++;
        done_cyc = cyc;
        start    = 1'b0;
        break;
      end
      if (abort) begin
        aborted = 1'b1;
        @(posedge clk);
        #1 abort = 1'b0;
        break;
      end
    end
    start = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1; start = 1'b0; abort = 1'b0; ready = 1'b1;
    target = 21'h15555;
    rom_const(1000);
    repeat (2) @(posedge clk);
    @(negedge clk);
    checks++;
    if ({busy, done, iv, dir} !== 4'b0001) begin
      errors++;
      $display("FAIL reset_flags: got busy/done/iv/dir=%b want 0001",
               {busy, done, iv, dir});
    end
    checks++;
    if (addr !== 4'd0 || res !== 21'd0) begin
      errors++;
      $display("FAIL reset_regs: got addr=%0d res=%h want 0/0", addr, res);
    end
    rst = 1'b0;
  endtask

  task automatic test_const_rom();
    int dc, nd, r;
    bit ab;
    int want_dir [16];
    want_dir = '{1,1,1,1,0,1,0,1,0,1,0,1,0,1,0,1};
    rom_const(1000);
    model_run(3500, r);
    run_op(3500, -1, 0, 0, 0, -1, dc, nd, ab);
    checks++;
    if (q_dir.size() != 16 || dc != 17) begin
      errors++;
      $display("FAIL const_latency: got iters=%0d done_cyc=%0d want 16/17",
               q_dir.size(), dc);
    end else begin
      for (int i = 0; i < 16; i++) begin
        checks++;
        if (q_dir[i] != want_dir[i] || q_addr[i] != i
            || q_dir[i] != int'(exp_dir[i])) begin
          errors++;
          $display("FAIL const_iter%0d: got addr=%0d dir=%0d want %0d/%0d",
                   i, q_addr[i], q_dir[i], i, want_dir[i]);
        end
      end
    end
    checks++;
    if (res !== 21'h1FFE0C || res !== 21'(r)) begin
      errors++;
      $display("FAIL const_residual: got %h want 1ffe0c", res);
    end
    @(negedge clk);
    checks++;
    if (busy !== 1'b0 || done !== 1'b0 || addr !== 4'd0) begin
      errors++;
      $display("FAIL const_idle: got busy=%b done=%b addr=%0d want 0/0/0",
               busy, done, addr);
    end
  endtask

  task automatic test_stall();
    int dc, nd, r;
    bit ab;
    rom_const(1000);
    model_run(3500, r);
    run_op(3500, 5, 3, 0, 0, -1, dc, nd, ab);
    checks++;
    if (stall_seen != 3 || stall_bad != 0) begin
      errors++;
      $display("FAIL stall_hold: got stalls=%0d bad=%0d want 3/0",
               stall_seen, stall_bad);
    end
    checks++;
    if (dc != 20 || q_addr.size() != 16) begin
      errors++;
      $display("FAIL stall_latency: got done_cyc=%0d iters=%0d want 20/16",
               dc, q_addr.size());
    end
    checks++;
    if (res !== 21'(r)) begin
      errors++;
      $display("FAIL stall_residual: got %h want %h", res, 21'(r));
    end
  endtask

  task automatic test_atan();
    int dc, nd, r, rs;
    bit ab;
    int nbad;
    rom_atan();
    model_run(0, r);
    run_op(0, -1, 0, 0, 0, -1, dc, nd, ab);
    nbad = 0;
    for (int i = 0; i < q_dir.size(); i++)
      if (i >= 16 || q_dir[i] != int'(exp_dir[i])) nbad++;
    checks++;
    if (q_dir.size() != 16 || nbad != 0) begin
      errors++;
      $display("FAIL atan_dirs: got iters=%0d wrong=%0d want 16/0",
               q_dir.size(), nbad);
    end
    rs = s21(longint'(res));
    checks++;
    if (res !== 21'(r) || rs > int'(rom[15]) || rs < -int'(rom[15])) begin
      errors++;
      $display("FAIL atan_residual: got %0d want %0d (bound %0d)",
               rs, r, rom[15]);
    end
  endtask

  task automatic test_abort();
    int dc, nd, r;
    bit ab;
    logic [20:0] prior;
    rom_const(1000);
    prior = res;
    run_op(1234, -1, 0, 0, 0, 7, dc, nd, ab);
    checks++;
    if (!ab || nd != 0) begin
      errors++;
      $display("FAIL abort_taken: got aborted=%0d dones=%0d want 1/0", ab, nd);
    end
    @(negedge clk);
    checks++;
    if (busy !== 1'b0 || done !== 1'b0 || res !== prior || addr !== 4'd0) begin
      errors++;
      $display("FAIL abort_idle: got busy=%b done=%b res=%h want 0/0/%h",
               busy, done, res, prior);
    end
    model_run(2222, r);
    run_op(2222, -1, 0, 0, 0, -1, dc, nd, ab);
    checks++;
    if (q_addr.size() != 16 || dc != 17 || res !== 21'(r)) begin
      errors++;
      $display("FAIL abort_restart: got iters=%0d done_cyc=%0d res=%h want 16/17/%h",
               q_addr.size(), dc, res, 21'(r));
    end
  endtask

  task automatic test_start_ignored();
    int dc, nd, r, extra;
    bit ab;
    int tgt;
    rom_atan();
    tgt = int'($urandom_range(0, 21'h1FFFFF));
    model_run(tgt, r);
    run_op(tgt, -1, 0, 0, 1, -1, dc, nd, ab);
    extra = 0;
    repeat (10) begin
      @(negedge clk);
      #1;
      if (done || busy) extra++;
    end
    checks++;
    if (nd != 1 || dc != 17 || extra != 0 || res !== 21'(r)) begin
      errors++;
      $display("FAIL start_ignored: got dones=%0d done_cyc=%0d extra=%0d res=%h want 1/17/0/%h",
               nd, dc, extra, res, 21'(r));
    end
  endtask

  task automatic test_reset_mid();
    rom_const(1000);
    @(negedge clk);
    start = 1'b1; target = 21'd77777; ready = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (5) @(negedge clk);
    checks++;
    if (busy !== 1'b1) begin
      errors++;
      $display("FAIL rstmid_busy: got busy=%b want 1", busy);
    end
    rst = 1'b1;
    @(negedge clk);
    checks++;
    if ({busy, done, iv, dir} !== 4'b0001 || addr !== 4'd0 || res !== 21'd0) begin
      errors++;
      $display("FAIL rstmid_outputs: got flags=%b addr=%0d res=%h want 0001/0/0",
               {busy, done, iv, dir}, addr, res);
    end
    rst = 1'b0;
  endtask

  task automatic test_wrap();
    int dc, nd, r;
    bit ab;
    rom_const(1000);
    model_run(32'h0FFFFF, r);
    run_op(32'h0FFFFF, -1, 0, 0, 0, -1, dc, nd, ab);
    checks++;
    if (res !== 21'(r) || res !== 21'(32'h0FFFFF - 16000)) begin
      errors++;
      $display("FAIL wrap_residual: got %h want %h", res, 21'(r));
    end
    rom_atan();
    rom[0] = 21'h0FFFFF;
    model_run(32'h100001, r);
    run_op(32'h100001, -1, 0, 0, 0, -1, dc, nd, ab);
    checks++;
    if (res !== 21'(r)) begin
      errors++;
      $display("FAIL wrap_modulo: got %h want %h", res, 21'(r));
    end
  endtask

  task automatic test_random();
    int dc, nd, r, nbad, tgt;
    bit ab;
    rom_atan();
    for (int k = 0; k < 20; k++) begin
      tgt = int'($urandom_range(0, 21'h1FFFFF));
      model_run(tgt, r);
      run_op(tgt, -1, 0, 1, 0, -1, dc, nd, ab);
      nbad = 0;
      for (int i = 0; i < q_dir.size(); i++)
        if (i >= 16 || q_dir[i] != int'(exp_dir[i]) || q_addr[i] != i) nbad++;
      checks++;
      if (nd != 1 || q_dir.size() != 16 || nbad != 0 || res !== 21'(r)) begin
        errors++;
        $display("FAIL random%0d: got dones=%0d iters=%0d wrong=%0d res=%h want 1/16/0/%h",
                 k, nd, q_dir.size(), nbad, res, 21'(r));
      end
    end
  endtask

  initial begin
    test_reset();
    test_const_rom();
    test_stall();
    test_atan();
    test_abort();
    test_start_ignored();
    test_reset_mid();
    test_wrap();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
